// File: rtl/color_sensor_pkg.sv
// color_sensor_pkg: shared register map, address, device id and FSM encoding for the 7'h44 RGB colour sensor.
package color_sensor_pkg;
  localparam logic [6:0] CS_ADDRESS     = 7'h44;
  localparam logic [7:0] CS_DEVICE_ID   = 8'h7D;
  localparam logic [7:0] CS_ID_REG      = 8'h00;
  localparam logic [7:0] CS_CONFIG_REG1 = 8'h01;
  localparam logic [7:0] CS_CONFIG_REG2 = 8'h02;
  localparam logic [7:0] CS_CONFIG_REG3 = 8'h03;
  localparam logic [7:0] CS_STATUS      = 8'h08;
  localparam logic [7:0] CS_G_LOW       = 8'h09;
  localparam logic [7:0] CS_G_HIGH      = 8'h0A;
  localparam logic [7:0] CS_R_LOW       = 8'h0B;
  localparam logic [7:0] CS_R_HIGH      = 8'h0C;
  localparam logic [7:0] CS_B_LOW       = 8'h0D;
  localparam logic [7:0] CS_B_HIGH      = 8'h0E;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_MACK
  } cs_state_t;

  // src is {status, B_H, B_L, R_H, R_L, G_H, G_L}; cfg is {config3, config2, config1}
  function automatic logic [7:0] cs_read_reg(input logic [7:0] ptr, input logic [7:0] id,
                                             input logic [23:0] cfg, input logic [55:0] src);
    logic [7:0] r;
    case (ptr)
      CS_ID_REG:      r = id;
      CS_CONFIG_REG1: r = cfg[7:0];
      CS_CONFIG_REG2: r = cfg[15:8];
      CS_CONFIG_REG3: r = cfg[23:16];
      CS_STATUS:      r = src[55:48];
      CS_G_LOW:       r = src[7:0];
      CS_G_HIGH:      r = src[15:8];
      CS_R_LOW:       r = src[23:16];
      CS_R_HIGH:      r = src[31:24];
      CS_B_LOW:       r = src[39:32];
      CS_B_HIGH:      r = src[47:40];
      default:        r = 8'h00;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: 2-FF synchronisers on scl/sda with registered edge and START/STOP pulses (3 cycles from pin).
module i2c_line_sync (
  input  logic clock_25mhz,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  logic [2:0] scl_q, sda_q;
  logic rise_q, fall_q, start_q, stop_q;
  // reset to the idle-high bus level so release of reset never looks like an edge
  always_ff @(posedge clock_25mhz) begin
    if (reset) begin
      scl_q   <= 3'b111;
      sda_q   <= 3'b111;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      scl_q   <= {scl_q[1:0], scl_i};
      sda_q   <= {sda_q[1:0], sda_i};
      rise_q  <= scl_q[1] & ~scl_q[2];
      fall_q  <= ~scl_q[1] & scl_q[2];
      start_q <= scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
      stop_q  <= scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    end
  end
  assign sda_o      = sda_q[2];
  assign scl_rise_o = rise_q;
  assign scl_fall_o = fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
endmodule

// File: rtl/i2c_color_sensor_responder.sv
// i2c_color_sensor_responder: I2C target emulating the 7'h44 RGB colour sensor.
// Define I2C_RESP_SNAPSHOT_EN to serve each read burst from a shadow captured at address match.
module i2c_color_sensor_responder
  import color_sensor_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = CS_ADDRESS,
  parameter logic [7:0] DEVICE_ID = CS_DEVICE_ID
) (
  input  logic        clock_25mhz,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [47:0] rgb_in,
  input  logic [7:0]  status_in,
  output logic [7:0]  config1,
  output logic [7:0]  config2,
  output logic [7:0]  config3,
  output logic        cfg_wr,
  output logic        busy
);
  logic sda_s, scl_rise, scl_fall, start_det, stop_det;
  cs_state_t state_q;
  logic [3:0] cnt_q;
  logic [7:0] shift_q, ptr_q, cfg1_q, cfg2_q, cfg3_q;
  logic rw_q, nack_q, oe_q, cfg_wr_q, busy_q;
  logic [55:0] src;
  logic [7:0] ptr_nx, rd_cur, rd_nx;
  logic addr_hit, byte_end;

  i2c_line_sync u_sync (
    .clock_25mhz(clock_25mhz),
    .reset      (reset),
    .scl_i      (scl_in),
    .sda_i      (sda_in),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  assign addr_hit = shift_q[7:1] == DEV_ADDR;
  assign byte_end = scl_fall && cnt_q == 4'd8;
  assign ptr_nx   = ptr_q + 8'd1;
  assign rd_cur   = cs_read_reg(ptr_q, DEVICE_ID, {cfg3_q, cfg2_q, cfg1_q}, src);
  assign rd_nx    = cs_read_reg(ptr_nx, DEVICE_ID, {cfg3_q, cfg2_q, cfg1_q}, src);

`ifdef I2C_RESP_SNAPSHOT_EN
  logic [55:0] snap_q;
  always_ff @(posedge clock_25mhz) begin
    if (reset) snap_q <= 56'h0;
    else if (state_q == ST_ADDR && byte_end && addr_hit && shift_q[0]) snap_q <= {status_in, rgb_in};
  end
  assign src = snap_q;
`else
  assign src = {status_in, rgb_in};
`endif

  always_ff @(posedge clock_25mhz) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      shift_q  <= 8'h00;
      ptr_q    <= 8'h00;
      cfg1_q   <= 8'h00;
      cfg2_q   <= 8'h00;
      cfg3_q   <= 8'h00;
      rw_q     <= 1'b0;
      nack_q   <= 1'b0;
      oe_q     <= 1'b0;
      cfg_wr_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cfg_wr_q <= 1'b0;
      if (stop_det) begin
        state_q <= ST_IDLE;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else if (start_det) begin
        state_q <= ST_ADDR;
        cnt_q   <= 4'd0;
        oe_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR, ST_REG, ST_WDATA: begin
            if (scl_rise && cnt_q != 4'd8) begin
              shift_q <= {shift_q[6:0], sda_s};
              cnt_q   <= cnt_q + 4'd1;
            end else if (byte_end) begin
              cnt_q <= 4'd0;
              if (state_q == ST_ADDR) begin
                state_q <= addr_hit ? ST_ADDR_ACK : ST_IDLE;
                oe_q    <= addr_hit;
                busy_q  <= addr_hit;
                rw_q    <= shift_q[0];
              end else if (state_q == ST_REG) begin
                ptr_q   <= shift_q;
                state_q <= ST_REG_ACK;
                oe_q    <= 1'b1;
              end else begin
                if (ptr_q == CS_CONFIG_REG1) cfg1_q <= shift_q;
                if (ptr_q == CS_CONFIG_REG2) cfg2_q <= shift_q;
                if (ptr_q == CS_CONFIG_REG3) cfg3_q <= shift_q;
                cfg_wr_q <= ptr_q == CS_CONFIG_REG1 || ptr_q == CS_CONFIG_REG2 || ptr_q == CS_CONFIG_REG3;
                ptr_q    <= ptr_nx;
                state_q  <= ST_WDATA_ACK;
                oe_q     <= 1'b1;
              end
            end
          end
          ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              cnt_q <= 4'd0;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                shift_q <= rd_cur;
                oe_q    <= ~rd_cur[7];
                state_q <= ST_RDATA;
              end else begin
                oe_q    <= 1'b0;
                state_q <= state_q == ST_ADDR_ACK ? ST_REG : ST_WDATA;
              end
            end
          end
          ST_RDATA: begin
            if (scl_rise) cnt_q <= cnt_q + 4'd1;
            else if (byte_end) begin
              oe_q    <= 1'b0;
              state_q <= ST_MACK;
            end else if (scl_fall) begin
              shift_q <= {shift_q[6:0], 1'b0};
              oe_q    <= ~shift_q[6];
            end
          end
          ST_MACK: begin
            if (scl_rise) nack_q <= sda_s;
            else if (scl_fall) begin
              cnt_q <= 4'd0;
              if (nack_q) begin
                oe_q    <= 1'b0;
                state_q <= ST_IDLE;
              end else begin
                ptr_q   <= ptr_nx;
                shift_q <= rd_nx;
                oe_q    <= ~rd_nx[7];
                state_q <= ST_RDATA;
              end
            end
          end
          default: oe_q <= 1'b0;
        endcase
      end
    end
  end

  assign sda_oe  = oe_q;
  assign config1 = cfg1_q;
  assign config2 = cfg2_q;
  assign config3 = cfg3_q;
  assign cfg_wr  = cfg_wr_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_i2c_color_sensor_responder.sv
// tb_i2c_color_sensor_responder: directed bus-controller bench for the colour sensor responder.
module tb_i2c_color_sensor_responder;
  localparam int Q = 62;
  logic clk = 1'b0;
  logic reset, scl_m, sda_m, sda_bus, sda_oe, cfg_wr, busy;
  logic [47:0] rgb_in;
  logic [7:0] status_in, config1, config2, config3;
  int checks = 0;
  int errors = 0;
  int cfg_wr_cnt = 0;

  always #20 clk = ~clk;
  assign sda_bus = sda_m & ~sda_oe;
  always @(posedge clk) if (cfg_wr) cfg_wr_cnt <= cfg_wr_cnt + 1;

  i2c_color_sensor_responder dut (
    .clock_25mhz(clk),
    .reset      (reset),
    .scl_in     (scl_m),
    .sda_in     (sda_bus),
    .sda_oe     (sda_oe),
    .rgb_in     (rgb_in),
    .status_in  (status_in),
    .config1    (config1),
    .config2    (config2),
    .config3    (config3),
    .cfg_wr     (cfg_wr),
    .busy       (busy)
  );

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b1; wait_clks(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    b = sda_bus;  wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
    ack = ~a;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic test_reset;
    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    rgb_in = 48'h0; status_in = 8'h5C;
    wait_clks(5);
    checks += 5;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
    if (config1 !== 8'h00) begin errors++; $display("FAIL reset_config1 got %h want 00", config1); end
    if ({config2, config3} !== 16'h0) begin errors++; $display("FAIL reset_config23 got %h want 0000", {config2, config3}); end
    if (cfg_wr !== 1'b0) begin errors++; $display("FAIL reset_cfg_wr got %b want 0", cfg_wr); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0;
    wait_clks(10);
  endtask

  task automatic test_config_write;
    logic a0, a1, a2;
    int c0;
    c0 = cfg_wr_cnt;
    i2c_start;
    write_byte(8'h88, a0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_high got %b want 1", busy); end
    write_byte(8'h01, a1);
    write_byte(8'h05, a2);
    i2c_stop;
    wait_clks(10);
    checks += 5;
    if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL write_acks got %b want 111", {a0, a1, a2}); end
    if (config1 !== 8'h05) begin errors++; $display("FAIL write_config1 got %h want 05", config1); end
    if (config2 !== 8'h00) begin errors++; $display("FAIL write_config2 got %h want 00", config2); end
    if (cfg_wr_cnt - c0 !== 1) begin errors++; $display("FAIL write_cfg_wr_pulses got %0d want 1", cfg_wr_cnt - c0); end
    if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop got %b want 0", busy); end
  endtask

  task automatic test_burst_read;
    logic a0, a1, a2;
    logic [7:0] d;
    logic [7:0] exp_b [6] = '{8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB};
    rgb_in = 48'hBBAA_9988_7766;
    i2c_start;
    write_byte(8'h88, a0);
    write_byte(8'h09, a1);
    i2c_start;
    write_byte(8'h89, a2);
    checks++;
    if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL burst_acks got %b want 111", {a0, a1, a2}); end
    for (int i = 0; i < 6; i++) begin
      read_byte(d, i == 5);
      checks++;
      if (d !== exp_b[i]) begin errors++; $display("FAIL burst_byte%0d got %h want %h", i, d, exp_b[i]); end
    end
    wait_clks(10);
    checks++;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL burst_release got %b want 0", sda_oe); end
    i2c_stop;
  endtask

  task automatic test_bad_addr;
    logic a;
    i2c_start;
    write_byte(8'h8A, a);
    checks += 2;
    if (a !== 1'b0) begin errors++; $display("FAIL badaddr_ack got %b want 0", a); end
    if (busy !== 1'b0) begin errors++; $display("FAIL badaddr_busy got %b want 0", busy); end
    i2c_stop;
    wait_clks(10);
    checks++;
    if (config1 !== 8'h05) begin errors++; $display("FAIL badaddr_config1 got %h want 05", config1); end
  endtask

  task automatic test_snapshot;
    logic a0, a1, a2;
    logic [7:0] d;
`ifdef I2C_RESP_SNAPSHOT_EN
    logic [7:0] exp_b [3] = '{8'h01, 8'h02, 8'h03};
`else
    logic [7:0] exp_b [3] = '{8'h01, 8'hF2, 8'hF3};
`endif
    rgb_in = 48'h0605_0403_0201;
    i2c_start;
    write_byte(8'h88, a0);
    write_byte(8'h09, a1);
    i2c_start;
    write_byte(8'h89, a2);
    rgb_in = 48'hF6F5_F4F3_F2F1;
    checks++;
    if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL snap_acks got %b want 111", {a0, a1, a2}); end
    for (int i = 0; i < 3; i++) begin
      read_byte(d, i == 2);
      checks++;
      if (d !== exp_b[i]) begin errors++; $display("FAIL snap_byte%0d got %h want %h", i, d, exp_b[i]); end
    end
    i2c_stop;
  endtask

  task automatic test_ptr_wrap;
    logic a0, a1, a2;
    logic [7:0] d;
    logic [7:0] exp_b [3] = '{8'h00, 8'h00, 8'h7D};
    i2c_start;
    write_byte(8'h88, a0);
    write_byte(8'hFE, a1);
    i2c_start;
    write_byte(8'h89, a2);
    checks++;
    if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL wrap_acks got %b want 111", {a0, a1, a2}); end
    for (int i = 0; i < 3; i++) begin
      read_byte(d, i == 2);
      checks++;
      if (d !== exp_b[i]) begin errors++; $display("FAIL wrap_byte%0d got %h want %h", i, d, exp_b[i]); end
    end
    i2c_stop;
  endtask

  task automatic test_reset_mid_ack;
    logic a0, a1, a2;
    i2c_start;
    for (int i = 7; i >= 0; i--) write_bit(8'h88 >> i);
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    checks++;
    if (sda_oe !== 1'b1) begin errors++; $display("FAIL midack_driving got %b want 1", sda_oe); end
    reset = 1'b1;
    wait_clks(1);
    checks += 2;
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL midack_release got %b want 0", sda_oe); end
    if (config1 !== 8'h00) begin errors++; $display("FAIL midack_config1 got %h want 00", config1); end
    wait_clks(3);
    reset = 1'b0;
    wait_clks(Q);
    i2c_start;
    write_byte(8'h88, a0);
    write_byte(8'h03, a1);
    write_byte(8'hC3, a2);
    i2c_stop;
    wait_clks(10);
    checks += 3;
    if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL after_reset_acks got %b want 111", {a0, a1, a2}); end
    if (config3 !== 8'hC3) begin errors++; $display("FAIL after_reset_config3 got %h want c3", config3); end
    if (busy !== 1'b0) begin errors++; $display("FAIL after_reset_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset;
    test_config_write;
    test_burst_read;
    test_bad_addr;
    test_snapshot;
    test_ptr_wrap;
    test_reset_mid_ack;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
